// File: rtl/insert_fifo.sv
// rtl/insert_fifo.sv - serialises one AES result block MSB-byte-first into the outbound byte FIFO
//
// Purpose: holds a 128-bit (8*BLOCK_BYTES) block and pushes it one byte per cycle into the
// USB transmit data FIFO, stalling on fifo_full. eof_out marks the final byte of a last block.
//
// Optional feature macro: INSERT_TRIM_EN
//   defined   - a last block sends only block_nbytes bytes (0 or >BLOCK_BYTES means all)
//   undefined - block_nbytes is ignored, every block sends BLOCK_BYTES bytes
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous active-high reset
//   block_in      block to send, byte 0 in the top byte
//   block_valid   block_in / block_last / block_nbytes valid
//   block_last    block is the final block of the message
//   block_nbytes  valid bytes in a last block (trim build only)
//   block_ready   block accepted on block_valid & block_ready
//   fifo_full     outbound FIFO full, no push while high
//   push          write strobe to outbound FIFO
//   data          byte to write, valid with push
//   eof_out       high with the push of the final byte of a last block
//   busy          block held, bytes outstanding
module insert_fifo #(
  parameter  int BLOCK_BYTES = 16,
  localparam int NB_W        = $clog2(BLOCK_BYTES + 1),
  localparam int BW          = 8 * BLOCK_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BW-1:0]   block_in,
  input  logic            block_valid,
  input  logic            block_last,
  input  logic [NB_W-1:0] block_nbytes,
  output logic            block_ready,
  input  logic            fifo_full,
  output logic            push,
  output logic [7:0]      data,
  output logic            eof_out,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [BW-1:0]   shreg_q;
  logic [NB_W-1:0] count_q;
  logic [NB_W-1:0] target_q;
  logic [NB_W-1:0] target_d;
  logic            last_q;

  logic accept;
  logic push_fire;
  logic last_byte;

  assign accept    = (state_q == IDLE) && block_valid;
  assign push_fire = (state_q == SEND) && !fifo_full;
  // target_q is never zero while in SEND, so target_q-1 cannot underflow there
  assign last_byte = (count_q == NB_W'(target_q - NB_W'(1)));

`ifdef INSERT_TRIM_EN
  always_comb begin
    target_d = NB_W'(BLOCK_BYTES);
    if (block_last && (block_nbytes != '0) && (block_nbytes <= NB_W'(BLOCK_BYTES)))
      target_d = block_nbytes;
  end
`else
  logic unused_nbytes;
  assign unused_nbytes = ^block_nbytes;
  assign target_d      = NB_W'(BLOCK_BYTES);
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // datapath: shift register shifts only on an actual push, so a stall holds the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      count_q  <= '0;
      target_q <= '0;
      last_q   <= 1'b0;
    end else if (accept) begin
      shreg_q  <= block_in;
      count_q  <= '0;
      target_q <= target_d;
      last_q   <= block_last;
    end else if (push_fire) begin
      shreg_q <= {shreg_q[BW-9:0], 8'h00};
      count_q <= count_q + NB_W'(1);
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (push_fire && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: decoded from registered state, fifo_full only gates the strobe
  always_comb begin
    block_ready = 1'b0;
    busy        = 1'b0;
    push        = 1'b0;
    data        = 8'h00;
    eof_out     = 1'b0;
    case (state_q)
      IDLE: block_ready = 1'b1;
      SEND: begin
        busy    = 1'b1;
        data    = shreg_q[BW-1 -: 8];
        push    = !fifo_full;
        eof_out = !fifo_full && last_q && last_byte;
      end
      default: block_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_insert_fifo.sv
// tb/tb_insert_fifo.sv - directed self-checking bench for insert_fifo
module tb_insert_fifo;

  localparam int BB   = 16;
  localparam int NB_W = 5;
  localparam logic [127:0] B1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] B2 = 128'hFFEEDDCCBBAA99887766554433221100;

  logic            clk = 1'b0;
  logic            rst;
  logic [127:0]    block_in;
  logic            block_valid;
  logic            block_last;
  logic [NB_W-1:0] block_nbytes;
  logic            block_ready;
  logic            fifo_full;
  logic            push;
  logic [7:0]      data;
  logic            eof_out;
  logic            busy;

  insert_fifo #(.BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .block_in(block_in), .block_valid(block_valid),
    .block_last(block_last), .block_nbytes(block_nbytes), .block_ready(block_ready),
    .fifo_full(fifo_full), .push(push), .data(data), .eof_out(eof_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_data[$];
  logic       q_eof[$];
  int         q_cyc[$];

  always @(negedge clk) begin
    if (push === 1'b1) begin
      q_data.push_back(data);
      q_eof.push_back(eof_out);
      q_cyc.push_back(cyc);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_eof.delete();
    q_cyc.delete();
  endtask

  function automatic logic [127:0] packed_bytes(input int start);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++)
      if (start + i < q_data.size()) r[127 - 8*i -: 8] = q_data[start + i];
    return r;
  endfunction

  function automatic int eof_count();
    int n = 0;
    foreach (q_eof[i]) if (q_eof[i]) n++;
    return n;
  endfunction

  function automatic int eof_index();
    foreach (q_eof[i]) if (q_eof[i]) return i;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_push"}, push, 1'b0);
    check({tag, "_data"}, data, 8'h00);
    check({tag, "_eof"}, eof_out, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ready"}, block_ready, 1'b1);
  endtask

  // Called at posedge+1 in IDLE. SEND cycle k (k=1 is the cycle after accept) is stalled
  // when stall_lo <= k <= stall_hi. Returns at posedge+1 of the first IDLE cycle.
  task automatic run_block(input logic [127:0] blk, input logic last, input logic [NB_W-1:0] nb,
                           input int stall_lo, input int stall_hi,
                           output int acc_cyc, output int done_cyc);
    int k = 1;
    int n = 0;
    block_in     = blk;
    block_last   = last;
    block_nbytes = nb;
    block_valid  = 1'b1;
    @(posedge clk); #1;
    acc_cyc     = cyc;
    block_valid = 1'b0;
    fifo_full   = (k >= stall_lo) && (k <= stall_hi);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      k++;
      n++;
      fifo_full = (k >= stall_lo) && (k <= stall_hi);
    end
    fifo_full = 1'b0;
    done_cyc  = cyc;
    check("block_timeout", n < 100, 1'b1);
  endtask

  initial begin
    int acc;
    int done;
    int n;

    rst          = 1'b0;
    block_in     = '0;
    block_valid  = 1'b0;
    block_last   = 1'b0;
    block_nbytes = '0;
    fifo_full    = 1'b0;
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // plain block, no stall
    clear_q();
    run_block(B1, 1'b0, 5'd16, 0, -1, acc, done);
    check("plain_count", q_data.size(), 16);
    check("plain_bytes", packed_bytes(0), B1);
    check("plain_eof_cnt", eof_count(), 0);
    check("plain_first_cyc", q_cyc[0], acc);
    check("plain_last_cyc", q_cyc[15], acc + 15);
    check("plain_done_cyc", done, acc + 16);
    check("plain_ready", block_ready, 1'b1);

    // fifo_full during SEND cycles 3..7
    clear_q();
    run_block(B1, 1'b0, 5'd16, 3, 7, acc, done);
    check("stall_count", q_data.size(), 16);
    check("stall_bytes", packed_bytes(0), B1);
    check("stall_push2_cyc", q_cyc[1], acc + 1);
    check("stall_push3_cyc", q_cyc[2], acc + 7);
    check("stall_done_cyc", done, acc + 21);

    // last block with nbytes=5
    clear_q();
    run_block(B1, 1'b1, 5'd5, 0, -1, acc, done);
`ifdef INSERT_TRIM_EN
    check("trim5_count", q_data.size(), 5);
    check("trim5_bytes", packed_bytes(0), 128'h0011223344_0000000000000000000000);
    check("trim5_eof_idx", eof_index(), 4);
    check("trim5_done_cyc", done, acc + 5);
`else
    check("trim5_count", q_data.size(), 16);
    check("trim5_bytes", packed_bytes(0), B1);
    check("trim5_eof_idx", eof_index(), 15);
    check("trim5_done_cyc", done, acc + 16);
`endif
    check("trim5_eof_cnt", eof_count(), 1);

    // last block, nbytes=0 (means full block), full raised on the final byte for 3 cycles
    clear_q();
    run_block(B1, 1'b1, 5'd0, 16, 18, acc, done);
    check("nb0_count", q_data.size(), 16);
    check("nb0_bytes", packed_bytes(0), B1);
    check("nb0_eof_cnt", eof_count(), 1);
    check("nb0_eof_idx", eof_index(), 15);
    check("nb0_last_cyc", q_cyc[15], acc + 18);
    check("nb0_done_cyc", done, acc + 19);

    // block_valid held across two blocks
    clear_q();
    block_in     = B1;
    block_last   = 1'b0;
    block_nbytes = 5'd16;
    block_valid  = 1'b1;
    @(posedge clk); #1;
    acc      = cyc;
    block_in = B2;
    n = 0;
    while (q_data.size() < 17 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_accept_timeout", n < 100, 1'b1);
    block_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_done_timeout", n < 100, 1'b1);
    done = cyc;
    check("b2b_count", q_data.size(), 32);
    check("b2b_bytes1", packed_bytes(0), B1);
    check("b2b_bytes2", packed_bytes(16), B2);
    check("b2b_second_first_cyc", q_cyc[16], acc + 17);
    check("b2b_done_cyc", done, acc + 33);

    // reset after the 8th push
    clear_q();
    block_in     = B1;
    block_last   = 1'b1;
    block_nbytes = 5'd16;
    block_valid  = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
    n = 0;
    while (q_data.size() < 8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst8_timeout", n < 100, 1'b1);
    rst = 1'b1;
    #1 check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_count", q_data.size(), 8);
    check("rst_mid_eof_cnt", eof_count(), 0);

    clear_q();
    run_block(B1, 1'b1, 5'd16, 0, -1, acc, done);
    check("post_rst_count", q_data.size(), 16);
    check("post_rst_bytes", packed_bytes(0), B1);
    check("post_rst_eof_idx", eof_index(), 15);
    check("post_rst_done_cyc", done, acc + 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
